// File: rtl/onehot_decode_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot strobe generator with hold, load and
// walking-one scan modes, a per-position dwell timer and a wrap pulse.
module onehot_decode_scan #(
    parameter int SEL_W = 3,
    parameter int DWELL = 1,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             valid,
    output logic             wrap
);

    localparam int CNT_W = ($clog2(DWELL) < 1) ? 1 : $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX  = '1;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_e;

    logic [SEL_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // Counter is shared by both scan directions, so a direction change keeps the dwell.
    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (clr) begin
            idx_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (en) begin
            case (mode_s)
                MODE_HOLD: begin
                    cnt_d = '0;
                end
                MODE_LOAD: begin
                    idx_d   = sel;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
                MODE_UP, MODE_DOWN: begin
                    if (!valid_q) begin
                        idx_d   = (mode_s == MODE_UP) ? '0 : IDX_MAX;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (mode_s == MODE_UP) begin
                            idx_d  = idx_q + SEL_W'(1);
                            wrap_d = (idx_q == IDX_MAX);
                        end else begin
                            idx_d  = idx_q - SEL_W'(1);
                            wrap_d = (idx_q == '0);
                        end
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    // Decoded purely from registers, so out can never disagree with idx/valid.
    always_comb begin
        out = '0;
        if (valid_q) begin
            out[idx_q] = 1'b1;
        end
    end

    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: doc/onehot_decode_scan.md
Name: onehot_decode_scan

Overview:
- Registered, parametrised successor to the team's 3-to-8 one-hot decoder.
- Decodes an SEL_W-bit index into a 2^SEL_W one-hot output. The output is registered.
- Adds a hold mode, a load mode, and an auto-scan (walking-one) mode that can run up or down, with a programmable dwell time and a wrap pulse.
- Used as a channel/row strobe generator: it drives scanned enables such as LED/mux columns, or selects a bank directly.

Parameters:
- SEL_W, 3, width of the select index. Must be >= 1. OUT_W = 2^SEL_W is derived internally, not overridable.
- DWELL, 1, number of enabled scan cycles spent on each position before advancing. Must be >= 1. The dwell counter width is max(1, clog2(DWELL)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. The block's only reset.
- clr  in  1  synchronous clear. Returns the block to the invalid state. Ignores en.
- en  in  1  clock enable for the mode logic. When 0, all state holds.
- mode  in  2  operation: 00 hold, 01 load, 10 scan up, 11 scan down.
- sel  in  SEL_W  index captured in load mode.
- out  out  OUT_W  registered one-hot strobe. All zero when not valid.
- idx  out  SEL_W  registered current index (binary).
- valid  out  1  high once a position has been loaded or scanning has started.
- wrap  out  1  single-cycle pulse on scan wrap-around.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, idx=0, valid=0, wrap=0, dwell counter=0. Outputs stay at these values until the first qualifying edge after rst_n rises.
- Invariant: out == (valid ? 1<<idx : 0) on every cycle, since both are derived from the same registers. out never has more than one bit set.
- Priority per edge is clr > en=0 > mode.
- clr=1: valid=0, idx=0, counter=0, wrap=0. Next cycle out=0.
- en=0: idx, valid and counter hold. wrap=0.
- Mode 00 (hold, en=1): idx and valid hold. Counter clears to 0. wrap=0.
- Mode 01 (load, en=1):
  - idx<=sel, valid<=1, counter<=0, wrap=0.
  - Latency 1 cycle: out=1<<sel on the cycle after the edge.
  - Back-to-back loads each take effect one cycle later.
- Mode 10/11 (scan, en=1) with valid=0 (start):
  - idx<=0 for up, idx<=OUT_W-1 for down.
  - valid<=1, counter<=0, wrap=0.
  - No advance occurs on the start edge.
- Mode 10/11 (scan, en=1) with valid=1:
  - If counter < DWELL-1: counter increments and idx holds.
  - If counter == DWELL-1: counter<=0 and idx advances by +1 (up) or -1 (down), modulo OUT_W.
  - With DWELL=1, idx advances on every enabled scan edge.
- wrap:
  - Asserted for exactly one cycle, registered alongside the idx change.
  - Fires when up advances OUT_W-1 -> 0, or down advances 0 -> OUT_W-1.
  - Never asserted on load, start, hold or clr.
- Direction change mid-dwell (10 <-> 11): counter is preserved and the next advance uses the new direction.
- Load during scan takes effect immediately and restarts the dwell from 0.
- Idle en cycles (en=0) do not count toward the dwell.
- SEL_W=1: OUT_W=2. Up and down scanning are equivalent; wrap fires on 1->0 (up) or 0->1 (down).
- No combinational path from any input to any output.

Test Plan:
- Reset and load (SEL_W=3): assert rst_n=0 mid-run -> out=0, valid=0 immediately. Release, then en=1, mode=01, sel=5 -> next cycle out=8'b0010_0000, idx=5, valid=1.
- Exhaustive load: sel=0..7 back-to-back -> out equals 1<<sel one cycle later. Compare every value against the original 3-to-8 truth table.
- Scan up, DWELL=1: start from invalid -> out sequence 01,02,04,...,80,01. wrap=1 only on the 80->01 cycle.
- Scan down, DWELL=3, en toggled 1,0,1: idx advances only after 3 enabled cycles; 7->6 occurs on schedule. Wrap on 0->7 fires one pulse.
- Mid-operation events:
  - Load sel=2 during an up scan at idx=6, counter=1 -> idx=2, counter=0.
  - Direction change mid-dwell keeps the count.
  - clr with en=0 -> out=0, valid=0.
- Hold and priority:
  - mode=00 for 10 cycles -> out is stable and wrap=0.
  - clr and load asserted together -> clr wins and out=0.
